// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: control, serial and parallel data in; register state and status out.
//  master : the block driving the shift register (controls/data out, status in)
//  slave  : the shift register itself
//  en, mode, start, dir, ser_in_r, ser_in_l, par_in : controls and data into the register
//  q, ser_out_r, ser_out_l, busy, done              : register contents, serial outputs, frame status
interface univ_shift_reg_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic             start;
  logic             dir;
  logic             ser_in_r;
  logic             ser_in_l;
  logic [WIDTH-1:0] par_in;
  logic [WIDTH-1:0] q;
  logic             ser_out_r;
  logic             ser_out_l;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, start, dir, ser_in_r, ser_in_l, par_in,
    input  q, ser_out_r, ser_out_l, busy, done
  );

  modport slave (
    input  en, mode, start, dir, ser_in_r, ser_in_l, par_in,
    output q, ser_out_r, ser_out_l, busy, done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift right / shift left / parallel load) with an automatic
// frame sequencer: a start pulse loads par_in, then WIDTH shifts in the latched direction
// serialize the word while the serial input is captured, followed by a one-cycle done state.
//  clk : clock, all state changes on posedge
//  rst : synchronous active-high reset
//  bus : univ_shift_reg_if slave modport (controls, serial/parallel data, q, busy, done)
module univ_shift_reg #(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  univ_shift_reg_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // One-hot encoding so busy and done come straight from state flops.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_SHIFT = 3'b010,
    ST_DONE  = 3'b100
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] shl;

  assign shr = {bus.ser_in_r, q_q[WIDTH-1:1]};
  assign shl = {q_q[WIDTH-2:0], bus.ser_in_l};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      q_q     <= RESET_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      q_q     <= q_d;
    end
  end

  // Next state, counter, latched direction and register contents; en=0 freezes everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    q_d     = q_q;
    if (bus.en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            q_d     = bus.par_in;
            dir_d   = bus.dir;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end else begin
            unique case (bus.mode)
              2'b00: q_d = q_q;
              2'b01: q_d = shr;
              2'b10: q_d = shl;
              2'b11: q_d = bus.par_in;
              default: q_d = q_q;
            endcase
          end
        end
        ST_SHIFT: begin
          q_d   = dir_q ? shl : shr;
          cnt_d = CNT_W'(cnt_q + 1'b1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are direct register bits.
  always_comb begin
    bus.q         = q_q;
    bus.ser_out_r = q_q[0];
    bus.ser_out_l = q_q[WIDTH-1];
    bus.busy      = state_q[1];
    bus.done      = state_q[2];
  end

endmodule
